cpu_mem_responder: RTL

Memory-side responder for the pipelined MIPS core's instruction-fetch and data-access ports. It serves both request channels from a single-port word-organised RAM, one access per cycle. Ready/valid handshakes let the core stall fetch or memory stage when it loses arbitration. Arbitration is data-first, with an anti-starvation override for fetch.

---
 rtl/cpu_mem_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the MIPS fetch and data ports: one single-port word RAM,
// one access per cycle, data-first arbitration with a one-cycle fetch starvation override.
module cpu_mem_responder #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        err
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        DFIRST = 1'b0,
        IFIRST = 1'b1
    } arb_t;

    arb_t              r_state;
    arb_t              w_state_nxt;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_bad_i;
    logic              w_bad_d;
    logic [ADDR_W-1:0] w_idx_i;
    logic [ADDR_W-1:0] w_idx_d;
    logic [31:0]       r_mem [DEPTH];
    logic              r_i_valid_p1;
    logic              r_d_valid_p1;
    logic              r_err_p1;
    logic [31:0]       r_i_rdata_p1;
    logic [31:0]       r_d_rdata_p1;

    function automatic logic f_bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
    endfunction

    assign w_bad_i = f_bad_addr(i_addr);
    assign w_bad_d = f_bad_addr(d_addr);
    assign w_idx_i = i_addr[ADDR_W+1:2];
    assign w_idx_d = d_addr[ADDR_W+1:2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DFIRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // IFIRST is the starvation flag: fetch lost arbitration on the previous edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DFIRST:  if (i_req && !w_grant_i) w_state_nxt = IFIRST;
            IFIRST:  if (w_grant_i) w_state_nxt = DFIRST;
            default: w_state_nxt = DFIRST;
        endcase
    end

    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (rst) begin
            if (i_req && (!d_req || r_state == IFIRST)) begin
                w_grant_i = 1'b1;
            end else if (d_req) begin
                w_grant_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant_d && d_we && !w_bad_d) begin
            r_mem[w_idx_d] <= d_wdata;
        end
    end

    // Stage p1: response registers, one cycle after the grant edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_valid_p1 <= 1'b0;
            r_d_valid_p1 <= 1'b0;
            r_err_p1     <= 1'b0;
            r_i_rdata_p1 <= '0;
            r_d_rdata_p1 <= '0;
        end else begin
            r_i_valid_p1 <= w_grant_i;
            r_d_valid_p1 <= w_grant_d;
            r_err_p1     <= (w_grant_i && w_bad_i) || (w_grant_d && w_bad_d);
            if (w_grant_i) begin
                r_i_rdata_p1 <= w_bad_i ? '0 : r_mem[w_idx_i];
            end
            if (w_grant_d) begin
                if (w_bad_d) begin
                    r_d_rdata_p1 <= '0;
                end else if (!d_we) begin
                    r_d_rdata_p1 <= r_mem[w_idx_d];
                end
            end
        end
    end

    assign i_ready = w_grant_i;
    assign d_ready = w_grant_d;
    assign i_valid = r_i_valid_p1;
    assign d_valid = r_d_valid_p1;
    assign i_rdata = r_i_rdata_p1;
    assign d_rdata = r_d_rdata_p1;
    assign err     = r_err_p1;

endmodule
